bist_session_scheduler: RTL and testbench

//  Shares one BIST controller among N requesters using round-robin arbitration.
//  Per granted session: issues the controller start pulse, tracks running / bist_end,

---
 rtl/bist_session_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_bist_session_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_session_scheduler.sv
// bist_session_scheduler
// Shares one BIST controller among N_REQ requesters with round-robin
// arbitration. Each granted session pulses ctrl_start, follows the
// controller through running / bist_end and reports pass/fail back to the
// owner. A watchdog pulls ctrl_reset high to recover a hung controller.
//
// Handshake: req_i is a one-cycle pulse that queues a session for that
// requester. The owner sees grant_o from START to REPORT. done_o pulses for
// one cycle to the owner. pass_o and timeout_o are meaningful only while
// done_o is non-zero. There is no back-pressure: requests are never dropped
// because each requester holds at most one queued session.
module bist_session_scheduler #(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 64,
  parameter int RST_CYC     = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [N_REQ-1:0] done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic             busy_o,
  output logic [7:0]       sess_cnt_o,
  output logic             ctrl_start_o,
  output logic             ctrl_reset_o,
  input  logic             ctrl_running_i,
  input  logic             ctrl_bist_end_i,
  input  logic             result_pass_i,
  output logic [2:0]       dbg_state_o
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_MAX = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
  localparam int WD_W   = $clog2(WD_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_RUN = 3'd2,
    S_RUN      = 3'd3,
    S_RECOVER  = 3'd4,
    S_REPORT   = 3'd5
  } state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   pend_q;
  logic [N_REQ-1:0]   pend_d;
  logic [PTR_W-1:0]   rr_q;
  logic [WD_W-1:0]    wd_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic               pass_q;
  logic               timeout_q;
  logic               busy_q;
  logic [7:0]         cnt_q;
  logic               start_q;
  logic               recover_q;

  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   idx_hi;
  logic [PTR_W-1:0]   idx_any;
  logic               found_hi;
  logic [N_REQ-1:0]   win_onehot;
  logic               start_now;
  logic               wd_expired;
  logic               rc_expired;

  // Round-robin pick: lowest pending index above rr_q, else lowest pending overall.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_any  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        idx_any = PTR_W'(i);
        if (i > int'(rr_q)) begin
          idx_hi   = PTR_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    win_idx    = found_hi ? idx_hi : idx_any;
    win_onehot = N_REQ'(1) << win_idx;
  end

  // Pending set: the winner is cleared on START entry; a coinciding req re-queues it.
  always_comb begin
    start_now  = (state_q == S_IDLE) && (pend_q != '0);
    pend_d     = (pend_q & ~(start_now ? win_onehot : '0)) | req_i;
    wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    rc_expired = (wd_q == WD_W'(RST_CYC - 1));
  end

  // Session FSM with registered outputs; wd_q doubles as the recovery hold counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      rr_q      <= PTR_W'(N_REQ - 1);
      wd_q      <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= 8'd0;
      start_q   <= 1'b0;
      recover_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      start_q   <= 1'b0;
      done_q    <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_now) begin
            state_q <= S_START;
            rr_q    <= win_idx;
            grant_q <= win_onehot;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_WAIT_RUN;
        end
        S_WAIT_RUN, S_RUN: begin
          if (ctrl_bist_end_i) begin
            state_q <= S_REPORT;
            done_q  <= grant_q;
            pass_q  <= result_pass_i;
            cnt_q   <= cnt_q + 8'd1;
          end else if (wd_expired) begin
            state_q   <= S_RECOVER;
            recover_q <= 1'b1;
            wd_q      <= '0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
            if (state_q == S_WAIT_RUN && ctrl_running_i) begin
              state_q <= S_RUN;
            end
          end
        end
        S_RECOVER: begin
          if (rc_expired) begin
            state_q   <= S_REPORT;
            recover_q <= 1'b0;
            done_q    <= grant_q;
            timeout_q <= 1'b1;
            cnt_q     <= cnt_q + 8'd1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_REPORT: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          grant_q   <= '0;
          busy_q    <= 1'b0;
          recover_q <= 1'b0;
        end
      endcase
    end
  end

  // The controller is reset immediately by a system reset, not only at the next edge.
  assign ctrl_reset_o = reset_i | recover_q;
  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign timeout_o    = timeout_q;
  assign busy_o       = busy_q;
  assign sess_cnt_o   = cnt_q;
  assign ctrl_start_o = start_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bist_session_scheduler.sv
// Bench for bist_session_scheduler: a transaction-level model predicts each
// session (owner, start cycle, report cycle, result) from the pending set and
// the round-robin pointer, and the DUT outputs are compared every cycle.
module tb_bist_session_scheduler;

  localparam int N = 3;
  localparam int T = 64;
  localparam int R = 4;
  localparam int W = N + 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i;
  logic [N-1:0] req_i;
  logic [N-1:0] grant_o;
  logic [N-1:0] done_o;
  logic         pass_o;
  logic         timeout_o;
  logic         busy_o;
  logic [7:0]   sess_cnt_o;
  logic         ctrl_start_o;
  logic         ctrl_reset_o;
  logic         ctrl_running_i;
  logic         ctrl_bist_end_i;
  logic         result_pass_i;
  logic [2:0]   dbg_state_o;

  bist_session_scheduler #(.N_REQ(N), .TIMEOUT_CYC(T), .RST_CYC(R)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .req_i           (req_i),
    .grant_o         (grant_o),
    .done_o          (done_o),
    .pass_o          (pass_o),
    .timeout_o       (timeout_o),
    .busy_o          (busy_o),
    .sess_cnt_o      (sess_cnt_o),
    .ctrl_start_o    (ctrl_start_o),
    .ctrl_reset_o    (ctrl_reset_o),
    .ctrl_running_i  (ctrl_running_i),
    .ctrl_bist_end_i (ctrl_bist_end_i),
    .result_pass_i   (result_pass_i),
    .dbg_state_o     (dbg_state_o)
  );

  // scoreboard / model state
  int           n_checks = 0;
  int           n_fail   = 0;
  int           k        = 0;
  logic [N-1:0] pend_m, req_last, req_cmd, own_m;
  int           rr_m, busy_until, start_c, report_c, lat_j;
  bit           hang_m;
  logic         res_m;
  logic [7:0]   cnt_m;
  int           sess_total;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] grant_log[$];
  int           rst_hi_cnt;
  int           lat_mode, lat_fix, res_mode;
  logic         res_fix;
  bit           noise_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_clear();
    pend_m     = '0;
    req_last   = '0;
    req_cmd    = '0;
    own_m      = '0;
    rr_m       = N - 1;
    busy_until = -1000;
    start_c    = -1000;
    report_c   = -1000;
    lat_j      = 1;
    hang_m     = 1'b0;
    res_m      = 1'b0;
    cnt_m      = 8'd0;
    sess_total = 0;
    exp_q.delete();
  endtask

  // Asynchronous reset applied mid-cycle; the controller reset must follow at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_i = 1'b1;
    #1;
    check("rst_ctrl_reset", ctrl_reset_o, 1);
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ctrl_start", ctrl_start_o, 0);
    req_i           = '0;
    ctrl_running_i  = 1'b0;
    ctrl_bist_end_i = 1'b0;
    result_pass_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sess_cnt", sess_cnt_o, 0);
    check("rst_done", done_o, 0);
    reset_i = 1'b0;
    model_clear();
    grant_log.delete();
  endtask

  // One clock: advance the model over the edge just passed, compare, drive next inputs.
  task automatic step();
    logic [W-1:0] e;
    int           rel;
    int           w;
    int           r;
    bit           in_sess;
    @(negedge clk);
    k++;
    if ((k - 1 > busy_until) && (pend_m != '0)) begin
      w = -1;
      for (int o = 1; o <= N; o++) begin
        if (w < 0 && pend_m[(rr_m + o) % N]) w = (rr_m + o) % N;
      end
      own_m     = N'(1) << w;
      rr_m      = w;
      pend_m[w] = 1'b0;
      start_c   = k;
      hang_m    = 1'b0;
      if (lat_mode == 2) hang_m = 1'b1;
      else if (lat_mode == 1) lat_j = lat_fix;
      else begin
        r = $urandom_range(0, 15);
        if (r == 0) hang_m = 1'b1;
        else if (r == 1) lat_j = $urandom_range(T - 2, T);
        else lat_j = $urandom_range(1, 12);
      end
      res_m = (res_mode == 1) ? res_fix : 1'($urandom_range(0, 1));
      if (hang_m) begin
        report_c = k + T + R + 1;
        e = {own_m, 1'b0, 1'b1};
      end else begin
        report_c = k + lat_j + 1;
        e = {own_m, res_m, 1'b0};
      end
      busy_until = report_c;
      exp_q.push_back(e);
    end
    pend_m = pend_m | req_last;
    if (k == report_c) begin
      cnt_m++;
      sess_total++;
    end

    in_sess = (k >= start_c) && (k <= report_c);
    if (ctrl_start_o === 1'b1) grant_log.push_back(grant_o);
    if (ctrl_reset_o === 1'b1) rst_hi_cnt++;
    check("ctrl_start", ctrl_start_o, k == start_c);
    check("grant", grant_o, in_sess ? own_m : '0);
    check("busy", busy_o, in_sess);
    check("ctrl_reset", ctrl_reset_o, hang_m && (k >= start_c + T + 1) && (k <= start_c + T + R));
    check("sess_cnt", sess_cnt_o, cnt_m);
    if (k == report_c) begin
      check("exp_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("done", done_o, e[W-1:2]);
        check("pass", pass_o, e[1]);
        check("timeout", timeout_o, e[0]);
      end
    end else begin
      check("done_idle", done_o, 0);
    end

    req_i    = req_cmd;
    req_last = req_cmd;
    req_cmd  = '0;
    rel = k - start_c;
    if (rel >= 1 && (hang_m ? (rel <= T) : (rel <= lat_j))) begin
      ctrl_running_i  = hang_m || (rel < lat_j);
      ctrl_bist_end_i = !hang_m && (rel == lat_j);
      result_pass_i   = ctrl_bist_end_i ? res_m : 1'($urandom_range(0, 1));
    end else begin
      ctrl_running_i  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      ctrl_bist_end_i = noise_en ? ($urandom_range(0, 7) == 0) : 1'b0;
      result_pass_i   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_log(input string tag, input int n, input logic [3*N-1:0] exp_v);
    check({tag, "_len"}, grant_log.size(), n);
    for (int i = 0; i < n; i++) begin
      check(tag, (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, exp_v[i*N +: N]);
    end
    grant_log.delete();
  endtask

  initial begin
    reset_i         = 1'b1;
    req_i           = '0;
    ctrl_running_i  = 1'b0;
    ctrl_bist_end_i = 1'b0;
    result_pass_i   = 1'b0;
    lat_mode = 1; lat_fix = 10; res_mode = 1; res_fix = 1'b1; noise_en = 1'b0;
    rst_hi_cnt = 0;
    model_clear();
    do_reset();

    // single session: 10-cycle run, passing result
    req_cmd = 3'b001;
    step();
    repeat (20) step();
    check("single_cnt", sess_cnt_o, 1);
    check_log("single_grant", 1, {3'b000, 3'b000, 3'b001});

    // round-robin from reset pointer, then partial request set
    do_reset();
    lat_fix = 3; res_mode = 0;
    req_cmd = 3'b111;
    step();
    repeat (30) step();
    check_log("rr_111", 3, {3'b100, 3'b010, 3'b001});
    req_cmd = 3'b011;
    step();
    repeat (20) step();
    check_log("rr_011", 2, {3'b000, 3'b010, 3'b001});

    // watchdog: controller never ends
    lat_mode = 2;
    rst_hi_cnt = 0;
    req_cmd = 3'b001;
    step();
    repeat (80) step();
    check("wd_reset_len", rst_hi_cnt, R);
    grant_log.delete();

    // owner re-requests during its own session
    lat_mode = 1; lat_fix = 10;
    req_cmd = 3'b010;
    step();
    repeat (4) step();
    req_cmd = 3'b010;
    step();
    repeat (40) step();
    check_log("requeue", 2, {3'b000, 3'b010, 3'b010});

    // request coinciding with its own clear stays pending
    req_cmd = 3'b100;
    step();
    req_cmd = 3'b100;
    step();
    repeat (40) step();
    check_log("same_cycle", 2, {3'b000, 3'b100, 3'b100});

    // bist_end on the last watchdog cycle still counts as a normal end
    lat_fix = 64; res_mode = 1; res_fix = 1'b1;
    req_cmd = 3'b010;
    step();
    repeat (75) step();

    // session counter wrap with shortest sessions
    do_reset();
    lat_fix = 1; res_mode = 0;
    for (int c = 0; c < 1400 && sess_total < 256; c++) begin
      req_cmd = N'(1) << $urandom_range(0, N - 1);
      step();
    end
    check("wrap_total", sess_total, 256);
    check("wrap_cnt", sess_cnt_o, 0);
    repeat (10) step();

    // randomized traffic with noise on ignored controller inputs
    lat_mode = 0; noise_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      req_cmd = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
      step();
    end
    req_cmd = '0;
    repeat (80) step();
    noise_en = 1'b0;

    // reset in the middle of a running session
    lat_mode = 2;
    req_cmd = 3'b001;
    step();
    repeat (10) step();
    check("mid_busy_before", busy_o, 1);
    do_reset();
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
